max_reduce_ctrl: RTL and testbench
==================================

Name: max_reduce_ctrl

Overview:
- Sequencing controller for a shared two-operand W-bit max datapath, exact or approximate (BMF-synthesised).
- Accepts a stream of words over a valid/ready handshake and folds each frame of FRAME_LEN words into one maximum using the external max unit, one step per cycle.
- Tracks an exact shadow maximum alongside and counts steps where the max unit's result differs from the exact one. Gives the error statistics needed to qualify an approximate max unit in-system.

Parameters:
- W, 5, word width; also the width of the max unit's operands and result.
- FRAME_LEN, 8, words per frame; legal range is 1 to 2^16-1.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  controller can accept a word
- in_data  input  W  upstream word
- mx_a  output  W  max unit operand A (running accumulator)
- mx_b  output  W  max unit operand B (current word)
- mx_y  input  W  max unit result; combinational, same cycle
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts result
- out_max  output  W  frame max as computed by the max unit
- out_exact  output  W  exact frame max (shadow)
- out_err  output  CNT_W  mismatching steps in this frame
- err_total  output  CNT_W  mismatching steps since reset/clear, saturating
- frame_cnt  output  CNT_W  frames delivered since reset/clear, saturating
- clr_stats  input  1  clears err_total and frame_cnt

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset state: S_FIRST. acc=0, exact=0, idx=0, out_err=0, err_total=0, frame_cnt=0, out_valid=0, in_ready=1.
  - out_max mirrors acc; out_exact mirrors exact.
  - Reset mid-frame discards the partial frame; no output is produced for it.
- Handshakes:
  - An input is accepted when in_valid && in_ready.
  - A result is delivered when out_valid && out_ready.
  - in_ready = (state != S_OUT).
  - out_valid = (state == S_OUT).
  - mx_a = acc and mx_b = in_data at all times (pure wiring).
- State S_FIRST, on accept:
  - acc <= in_data; exact <= in_data; out_err <= 0; idx <= 1.
  - The max unit is not used for the first word.
  - Next state is S_OUT if FRAME_LEN==1, else S_ACC.
- State S_ACC, on accept:
  - ref = unsigned max(acc, in_data).
  - acc <= mx_y.
  - exact <= unsigned max(exact, in_data).
  - If mx_y != ref: out_err += 1 (saturating) and err_total += 1 (saturating at 2^CNT_W-1).
  - idx += 1.
  - If idx == FRAME_LEN-1 at accept, next state is S_OUT.
  - No accept means hold all state.
- State S_OUT:
  - out_max, out_exact and out_err are held stable until delivery.
  - On delivery: frame_cnt += 1 (saturating); next state is S_FIRST.
  - Without out_ready, all outputs hold indefinitely.
- Timing:
  - Throughput is one word per cycle within a frame.
  - Result is valid the cycle after the last word is accepted.
  - One bubble cycle on in_ready per frame (S_OUT), minimum.
- clr_stats:
  - Clears err_total and frame_cnt at the next edge.
  - If it coincides with an increment, the clear wins and the increment is dropped.
  - Does not affect out_err or the frame in progress.
- The error count measures per-step deviation against the max unit's own prior accumulator, not against the final result.
- Arithmetic is unsigned. Counters never wrap; they saturate.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst for 2 cycles, then release with in_valid=0 for 5 cycles.
  - Required: in_ready=1, out_valid=0, err_total=0, frame_cnt=0 throughout.
- Exact unit, W=5, FRAME_LEN=8:
  - Stimulus: max model mx_y=max(mx_a,mx_b); back-to-back frame 3,9,4,7,1,8,2,6.
  - Required: out_valid 1 cycle after the 8th accept; out_max=9, out_exact=9, out_err=0; frame_cnt=1 after delivery.
- LSB-dropping unit:
  - Stimulus: mx_y=max(a,b)&5'b11110; same frame.
  - Required: out_max=8, out_exact=9, out_err=1, err_total=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles at S_OUT with in_valid=1.
  - Required: in_ready=0 and outputs stable for those cycles. Raising out_ready delivers once; the next word is accepted the following cycle as the first word of a new frame.
- FRAME_LEN=1:
  - Stimulus: words 17 then 5.
  - Required: two results, 17 then 5, each with out_err=0; max unit unused; frame_cnt=2.
- Clear/reset collisions:
  - Stimulus: assert clr_stats in the same cycle as an out_ready delivery.
  - Required: frame_cnt=0 after the edge.
  - Stimulus: assert rst after the 4th word of a frame.
  - Required: no out_valid; next frame's results are correct.

Source files
------------

// File: rtl/max_reduce_ctrl.sv
// Folds fixed-length frames into one max through an external max unit,
// tracking an exact shadow max and counting steps where the unit deviates.
module max_reduce_ctrl #(
    parameter int W         = 5,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic [W-1:0]     mx_a,
    output logic [W-1:0]     mx_b,
    input  logic [W-1:0]     mx_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_max,
    output logic [W-1:0]     out_exact,
    output logic [CNT_W-1:0] out_err,
    output logic [CNT_W-1:0] err_total,
    output logic [CNT_W-1:0] frame_cnt,
    input  logic             clr_stats
);

    typedef enum logic [1:0] {
        S_FIRST,
        S_ACC,
        S_OUT
    } state_t;

    localparam logic [15:0]      LAST    = 16'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     exact_q, exact_d;
    logic [15:0]      idx_q, idx_d;
    logic [CNT_W-1:0] out_err_q, out_err_d;
    logic [CNT_W-1:0] err_total_q, err_total_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic         accept;
    logic         deliver;
    logic         err_inc;
    logic         frame_inc;
    logic [W-1:0] ref_max;
    logic [W-1:0] exact_max;

    assign in_ready  = (state_q != S_OUT);
    assign out_valid = (state_q == S_OUT);
    assign mx_a      = acc_q;
    assign mx_b      = in_data;
    assign out_max   = acc_q;
    assign out_exact = exact_q;
    assign out_err   = out_err_q;
    assign err_total = err_total_q;
    assign frame_cnt = frame_cnt_q;

    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign ref_max   = (acc_q > in_data) ? acc_q : in_data;
    assign exact_max = (exact_q > in_data) ? exact_q : in_data;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        exact_d   = exact_q;
        idx_d     = idx_q;
        out_err_d = out_err_q;
        err_inc   = 1'b0;
        frame_inc = 1'b0;

        unique case (state_q)
            S_FIRST: begin
                // first word seeds both accumulators; the max unit is bypassed
                if (accept) begin
                    acc_d     = in_data;
                    exact_d   = in_data;
                    out_err_d = '0;
                    idx_d     = 16'd1;
                    state_d   = (FRAME_LEN == 1) ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                if (accept) begin
                    acc_d   = mx_y;
                    exact_d = exact_max;
                    idx_d   = idx_q + 16'd1;
                    if (mx_y != ref_max) begin
                        err_inc = 1'b1;
                        if (out_err_q != CNT_MAX) begin
                            out_err_d = out_err_q + 1'b1;
                        end
                    end
                    if (idx_q == LAST) begin
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (deliver) begin
                    frame_inc = 1'b1;
                    state_d   = S_FIRST;
                end
            end
            default: state_d = S_FIRST;
        endcase
    end

    // a clear takes priority over any coincident increment
    always_comb begin
        err_total_d = err_total_q;
        frame_cnt_d = frame_cnt_q;
        if (clr_stats) begin
            err_total_d = '0;
            frame_cnt_d = '0;
        end else begin
            if (err_inc && err_total_q != CNT_MAX) begin
                err_total_d = err_total_q + 1'b1;
            end
            if (frame_inc && frame_cnt_q != CNT_MAX) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FIRST;
            acc_q       <= '0;
            exact_q     <= '0;
            idx_q       <= '0;
            out_err_q   <= '0;
            err_total_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            exact_q     <= exact_d;
            idx_q       <= idx_d;
            out_err_q   <= out_err_d;
            err_total_q <= err_total_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_max_reduce_ctrl.sv
// Randomised and directed bench for max_reduce_ctrl with a frame-level
// reference model and selectable exact / lossy max units.
module tb_max_reduce_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [4:0] in_data;
    logic       out_ready;
    logic       clr_stats;

    logic        r8, v8, r1, v1;
    logic [4:0]  a8, b8, y8, om8, oe8;
    logic [4:0]  a1, b1, y1, om1, oe1;
    logic [15:0] er8, et8, fc8, er1, et1, fc1;

    int mode;
    int sel;
    int total;
    int bad;
    int cyc;

    logic [4:0] fw[$];
    logic [4:0] e_max, e_ex;
    int         e_err;
    int         m_et;
    int         m_fc;

    function automatic logic [4:0] unit(int m, logic [4:0] a, logic [4:0] b);
        logic [4:0] mx, mn;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        case (m)
            0:       return mx;
            1:       return mx & 5'b11110;
            default: return (a[0] ^ b[0]) ? mn : mx;
        endcase
    endfunction

    function automatic logic [4:0] umax(logic [4:0] a, logic [4:0] b);
        return (a > b) ? a : b;
    endfunction

    assign y8 = unit(mode, a8, b8);
    assign y1 = unit(mode, a1, b1);

    max_reduce_ctrl #(.W(5), .FRAME_LEN(8), .CNT_W(16)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r8),
        .in_data(in_data), .mx_a(a8), .mx_b(b8), .mx_y(y8),
        .out_valid(v8), .out_ready(out_ready), .out_max(om8),
        .out_exact(oe8), .out_err(er8), .err_total(et8),
        .frame_cnt(fc8), .clr_stats(clr_stats)
    );

    max_reduce_ctrl #(.W(5), .FRAME_LEN(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
        .in_data(in_data), .mx_a(a1), .mx_b(b1), .mx_y(y1),
        .out_valid(v1), .out_ready(out_ready), .out_max(om1),
        .out_exact(oe1), .out_err(er1), .err_total(et1),
        .frame_cnt(fc1), .clr_stats(clr_stats)
    );

    logic        s_rdy, s_vld;
    logic [4:0]  s_om, s_oe;
    logic [15:0] s_er, s_et, s_fc;

    assign s_rdy = sel ? r1  : r8;
    assign s_vld = sel ? v1  : v8;
    assign s_om  = sel ? om1 : om8;
    assign s_oe  = sel ? oe1 : oe8;
    assign s_er  = sel ? er1 : er8;
    assign s_et  = sel ? et1 : et8;
    assign s_fc  = sel ? fc1 : fc8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [4:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!s_rdy && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic calc_expect();
        e_max = fw[0];
        e_ex  = fw[0];
        e_err = 0;
        if (sel == 0) begin
            for (int i = 1; i < fw.size(); i++) begin
                logic [4:0] y;
                y = unit(mode, e_max, fw[i]);
                if (y != umax(e_max, fw[i])) e_err++;
                e_max = y;
                e_ex  = umax(e_ex, fw[i]);
            end
        end
        m_et += e_err;
    endtask

    task automatic send_frame();
        int t0;
        calc_expect();
        push(fw[0]);
        t0 = cyc;
        for (int i = 1; i < fw.size(); i++) push(fw[i]);
        in_valid = 1'b0;
        chk("throughput", cyc - t0, fw.size() - 1);
        chk("latency_valid", s_vld, 1);
    endtask

    task automatic pop();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!s_vld && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("out_valid_timeout", 32'd0, 32'd1);
        chk("out_max", s_om, e_max);
        chk("out_exact", s_oe, e_ex);
        chk("out_err", s_er, e_err);
        tick();
        out_ready = 1'b0;
        m_fc++;
        chk("frame_cnt", s_fc, m_fc);
        chk("err_total", s_et, m_et);
        chk("valid_drop", s_vld, 0);
    endtask

    task automatic rand_frame(int n);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back(5'($urandom_range(0, 31)));
    endtask

    task automatic do_reset(int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst  = 1'b0;
        m_fc = 0;
        m_et = 0;
    endtask

    initial begin
        logic [4:0] hm, he;
        total     = 0;
        bad       = 0;
        sel       = 0;
        mode      = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        m_fc      = 0;
        m_et      = 0;

        do_reset(2);
        chk("rst_out_max", s_om, 0);
        chk("rst_out_exact", s_oe, 0);
        chk("rst_out_err", s_er, 0);
        for (int i = 0; i < 5; i++) begin
            chk("idle_in_ready", s_rdy, 1);
            chk("idle_out_valid", s_vld, 0);
            chk("idle_err_total", s_et, 0);
            chk("idle_frame_cnt", s_fc, 0);
            tick();
        end

        mode = 0;
        fw   = '{5'd3, 5'd9, 5'd4, 5'd7, 5'd1, 5'd8, 5'd2, 5'd6};
        send_frame();
        pop();

        mode = 1;
        send_frame();
        chk("lsb_max_is_8", s_om, 8);
        chk("lsb_err_is_1", s_er, 1);
        pop();

        mode = 0;
        rand_frame(8);
        send_frame();
        hm        = s_om;
        he        = s_oe;
        in_valid  = 1'b1;
        in_data   = 5'd22;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_in_ready", s_rdy, 0);
            chk("bp_valid", s_vld, 1);
            chk("bp_max_hold", s_om, hm);
            chk("bp_exact_hold", s_oe, he);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_fc++;
        chk("bp_deliver_once", s_fc, m_fc);
        chk("bp_ready_back", s_rdy, 1);
        rand_frame(7);
        fw.push_front(5'd22);
        send_frame();
        pop();

        for (int f = 0; f < 20; f++) begin
            mode = f % 3;
            rand_frame(8);
            send_frame();
            repeat ($urandom_range(0, 3)) tick();
            pop();
        end

        mode = 1;
        fw   = '{5'd3, 5'd9, 5'd4, 5'd7, 5'd1, 5'd8, 5'd2, 5'd6};
        send_frame();
        out_ready = 1'b1;
        clr_stats = 1'b1;
        tick();
        out_ready = 1'b0;
        clr_stats = 1'b0;
        m_fc = 0;
        m_et = 0;
        chk("clr_frame_cnt", s_fc, 0);
        chk("clr_err_total", s_et, 0);
        chk("clr_delivered", s_vld, 0);

        mode = 2;
        rand_frame(8);
        for (int i = 0; i < 4; i++) push(fw[i]);
        in_valid = 1'b0;
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_valid", s_vld, 0);
            tick();
        end
        rand_frame(8);
        send_frame();
        pop();

        do_reset(1);
        sel  = 1;
        mode = 1;
        fw   = '{5'd17};
        send_frame();
        pop();
        fw = '{5'd5};
        send_frame();
        pop();
        chk("fl1_frame_cnt", s_fc, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
